// File: rtl/mmio_bus_ctrl_if.sv
// CPU data-port bundle between the core (master) and the MMIO bus controller (slave).
// The request fields come from the CPU and the response fields come from the controller.
interface mmio_bus_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic        cpu_stall;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_sel, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_err, cpu_stall
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_sel, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_err, cpu_stall
  );
endinterface

// File: rtl/mmio_bus_ctrl.sv
// Sequences CPU data-port accesses onto the ROM data window, GRAM and data RAM.
// It decodes the address, times the read latency of each region and returns one registered ack.
module mmio_bus_ctrl #(
  parameter logic [31:0] ROM_BASE    = 32'h0000_0000,
  parameter logic [31:0] ROM_END     = 32'h0000_1000,
  parameter logic [31:0] GRAM_BASE   = 32'h0000_1000,
  parameter logic [31:0] GRAM_END    = 32'h0000_2000,
  parameter logic [31:0] RAM_BASE    = 32'h0001_0000,
  parameter int unsigned ROM_RD_LAT  = 1,
  parameter int unsigned GRAM_RD_LAT = 1,
  parameter int unsigned RAM_RD_LAT  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  mmio_bus_ctrl_if.slave        bus,
  output logic [31:0]           o_dev_addr,
  output logic [3:0]            o_dev_sel,
  output logic [31:0]           o_dev_wdata,
  output logic                  o_rom_ce,
  output logic                  o_gram_ce,
  output logic                  o_gram_we,
  output logic                  o_ram_ce,
  output logic                  o_ram_we,
  input  logic [31:0]           i_rom_rdata,
  input  logic [31:0]           i_gram_rdata,
  input  logic [31:0]           i_ram_rdata,
  output logic [7:0]            o_err_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {REG_NONE, REG_ROM, REG_GRAM, REG_RAM} region_t;

  localparam logic [3:0] ROM_LAT4  = 4'(ROM_RD_LAT);
  localparam logic [3:0] GRAM_LAT4 = 4'(GRAM_RD_LAT);
  localparam logic [3:0] RAM_LAT4  = 4'(RAM_RD_LAT);

  state_t      r_state;
  state_t      w_next_state;
  region_t     r_region;
  region_t     w_region;
  logic [3:0]  r_count;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_dev_addr;
  logic [3:0]  r_dev_sel;
  logic [31:0] r_dev_wdata;
  logic [7:0]  r_err_count;
  logic [31:0] w_base;
  logic [3:0]  w_lat;
  logic [31:0] w_slave_rdata;
  logic        w_in_rom;
  logic        w_in_gram;
  logic        w_in_ram;

  // Offset compares avoid a redundant "addr >= 0" test when a base is zero.
  assign w_in_rom  = (bus.cpu_addr - ROM_BASE) < (ROM_END - ROM_BASE);
  assign w_in_gram = (bus.cpu_addr - GRAM_BASE) < (GRAM_END - GRAM_BASE);
  assign w_in_ram  = bus.cpu_addr >= RAM_BASE;

  always_comb begin
    w_region = REG_NONE;
    w_base   = 32'h0;
    w_lat    = 4'h0;
    if (w_in_rom) begin
      w_region = REG_ROM;
      w_base   = ROM_BASE;
      w_lat    = ROM_LAT4;
    end else if (w_in_gram) begin
      w_region = REG_GRAM;
      w_base   = GRAM_BASE;
      w_lat    = GRAM_LAT4;
    end else if (w_in_ram) begin
      w_region = REG_RAM;
      w_base   = RAM_BASE;
      w_lat    = RAM_LAT4;
    end
  end

  always_comb begin
    w_slave_rdata = 32'h0;
    case (r_region)
      REG_ROM:  w_slave_rdata = i_rom_rdata;
      REG_GRAM: w_slave_rdata = i_gram_rdata;
      REG_RAM:  w_slave_rdata = i_ram_rdata;
      default:  w_slave_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.cpu_req) w_next_state = (w_region == REG_NONE) ? RESP : ACCESS;
      ACCESS:  if (r_count == 4'h0) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request latch, latency counter, return-data capture and error counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_region    <= REG_NONE;
      r_count     <= 4'h0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_dev_addr  <= 32'h0;
      r_dev_sel   <= 4'h0;
      r_dev_wdata <= 32'h0;
      r_err_count <= 8'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cpu_req) begin
            r_region    <= w_region;
            r_we        <= bus.cpu_we;
            r_err       <= (w_region == REG_NONE);
            r_rdata     <= 32'h0;
            r_count     <= bus.cpu_we ? 4'h0 : w_lat;
            r_dev_addr  <= bus.cpu_addr - w_base;
            r_dev_sel   <= bus.cpu_sel;
            r_dev_wdata <= bus.cpu_wdata;
          end
        end
        ACCESS: begin
          if (r_count == 4'h0) begin
            if (!r_we) r_rdata <= w_slave_rdata;
          end else begin
            r_count <= r_count - 4'h1;
          end
        end
        RESP: begin
          if (r_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'h1;
        end
        default: ;
      endcase
    end
  end

  // Writes to the ROM window are decoded as mapped but never reach the ROM.
  always_comb begin
    o_rom_ce      = 1'b0;
    o_gram_ce     = 1'b0;
    o_gram_we     = 1'b0;
    o_ram_ce      = 1'b0;
    o_ram_we      = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.cpu_err   = 1'b0;
    bus.cpu_rdata = 32'h0;
    case (r_state)
      ACCESS: begin
        case (r_region)
          REG_ROM: o_rom_ce = !r_we;
          REG_GRAM: begin
            o_gram_ce = 1'b1;
            o_gram_we = r_we;
          end
          REG_RAM: begin
            o_ram_ce = 1'b1;
            o_ram_we = r_we;
          end
          default: ;
        endcase
      end
      RESP: begin
        bus.cpu_ack   = 1'b1;
        bus.cpu_err   = r_err;
        bus.cpu_rdata = r_rdata;
      end
      default: ;
    endcase
    bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
  end

  assign o_dev_addr  = r_dev_addr;
  assign o_dev_sel   = r_dev_sel;
  assign o_dev_wdata = r_dev_wdata;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Randomized plus directed bench for mmio_bus_ctrl against a region/latency reference model.
// Each access is timed from the edge that samples the request to the edge that sees the ack.
module tb_mmio_bus_ctrl;

  localparam int ROM_LAT  = 2;
  localparam int GRAM_LAT = 1;
  localparam int RAM_LAT  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] devAddr, devWdata;
  logic [3:0]  devSel;
  logic        romCe, gramCe, gramWe, ramCe, ramWe;
  logic [31:0] romData, gramData, ramData;
  logic [7:0]  errCount;

  int assertCount = 0;
  int failCount   = 0;
  int modelErrCount = 0;

  always #5 clk = ~clk;

  mmio_bus_ctrl_if bus();

  mmio_bus_ctrl #(
    .ROM_RD_LAT(ROM_LAT), .GRAM_RD_LAT(GRAM_LAT), .RAM_RD_LAT(RAM_LAT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .o_dev_addr(devAddr), .o_dev_sel(devSel), .o_dev_wdata(devWdata),
    .o_rom_ce(romCe), .o_gram_ce(gramCe), .o_gram_we(gramWe),
    .o_ram_ce(ramCe), .o_ram_we(ramWe),
    .i_rom_rdata(romData), .i_gram_rdata(gramData), .i_ram_rdata(ramData),
    .o_err_count(errCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // 0 = unmapped, 1 = ROM, 2 = GRAM, 3 = data RAM
  function automatic int regionOf(input logic [31:0] a);
    if (a < 32'h1000) return 1;
    if (a < 32'h2000) return 2;
    if (a >= 32'h1_0000) return 3;
    return 0;
  endfunction

  function automatic int latOf(input int r);
    case (r)
      1: return ROM_LAT;
      2: return GRAM_LAT;
      3: return RAM_LAT;
      default: return 0;
    endcase
  endfunction

  // Called #1 after an edge with the controller idle; returns #1 after the following idle edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] wdata);
    int r, cycles, expLat, expCe, expWe;
    int nRomCe, nGramCe, nGramWe, nRamCe, nRamWe, stallBad;
    logic gotAck, ackErr;
    logic [31:0] ackData, expData, baseAddr;
    r = regionOf(addr);
    romData  = $urandom;
    gramData = $urandom;
    ramData  = $urandom;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_sel   = sel;
    bus.cpu_wdata = wdata;
    cycles = 0; gotAck = 1'b0; ackErr = 1'b0; ackData = 32'h0; stallBad = 0;
    nRomCe = 0; nGramCe = 0; nGramWe = 0; nRamCe = 0; nRamWe = 0;
    while (!gotAck && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      nRomCe += int'(romCe); nGramCe += int'(gramCe); nGramWe += int'(gramWe);
      nRamCe += int'(ramCe); nRamWe += int'(ramWe);
      if (bus.cpu_ack) begin
        gotAck  = 1'b1;
        ackErr  = bus.cpu_err;
        ackData = bus.cpu_rdata;
        checkOutput("stallAtAck", 32'(bus.cpu_stall), 32'd0);
      end else if (!bus.cpu_stall) begin
        stallBad++;
      end
    end
    bus.cpu_req = 1'b0;

    if (r == 0)      expLat = 1;
    else if (we)     expLat = 2;
    else             expLat = latOf(r) + 2;
    expCe = (r == 0 || (r == 1 && we)) ? 0 : (we ? 1 : latOf(r) + 1);
    expWe = (we && (r == 2 || r == 3)) ? 1 : 0;
    expData = 32'h0;
    if (!we && r == 1) expData = romData;
    if (!we && r == 2) expData = gramData;
    if (!we && r == 3) expData = ramData;
    baseAddr = (r == 2) ? 32'h1000 : ((r == 3) ? 32'h1_0000 : 32'h0);

    checkOutput("ack", 32'(gotAck), 32'd1);
    checkOutput("latency", 32'(cycles), 32'(expLat));
    checkOutput("stallBeforeAck", 32'(stallBad), 32'd0);
    checkOutput("rdata", ackData, expData);
    checkOutput("err", 32'(ackErr), (r == 0) ? 32'd1 : 32'd0);
    checkOutput("romCeCycles", 32'(nRomCe), (r == 1) ? 32'(expCe) : 32'd0);
    checkOutput("gramCeCycles", 32'(nGramCe), (r == 2) ? 32'(expCe) : 32'd0);
    checkOutput("ramCeCycles", 32'(nRamCe), (r == 3) ? 32'(expCe) : 32'd0);
    checkOutput("gramWeCycles", 32'(nGramWe), (r == 2) ? 32'(expWe) : 32'd0);
    checkOutput("ramWeCycles", 32'(nRamWe), (r == 3) ? 32'(expWe) : 32'd0);
    if (r != 0) checkOutput("devAddr", devAddr, addr - baseAddr);
    checkOutput("devSel", 32'(devSel), 32'(sel));
    checkOutput("devWdata", devWdata, wdata);

    if (r == 0 && modelErrCount < 255) modelErrCount++;
    @(posedge clk); #1;
    checkOutput("ackOneCycle", 32'(bus.cpu_ack), 32'd0);
    checkOutput("errCount", 32'(errCount), 32'(modelErrCount));
  endtask

  initial begin
    logic [31:0] boundary [6];
    logic [31:0] addr;
    int kind;
    boundary[0] = 32'h0000_0FFF; boundary[1] = 32'h0000_1000; boundary[2] = 32'h0000_1FFF;
    boundary[3] = 32'h0000_2000; boundary[4] = 32'h0000_FFFF; boundary[5] = 32'h0001_0000;

    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0;
    bus.cpu_sel = 4'h0; bus.cpu_wdata = 32'h0;
    romData = 32'h0; gramData = 32'h0; ramData = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstAck", 32'(bus.cpu_ack), 32'd0);
    checkOutput("rstRdata", bus.cpu_rdata, 32'd0);
    checkOutput("rstCe", 32'({romCe, gramCe, gramWe, ramCe, ramWe}), 32'd0);
    checkOutput("rstDevAddr", devAddr, 32'd0);
    checkOutput("rstErrCount", 32'(errCount), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 32'h0001_0010, 4'hF, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0000_1004, 4'hF, 32'h0);
    repeat (3) applyStimulus(1'b0, 32'h0000_8000, 4'hF, 32'h0);
    checkOutput("errCountThree", 32'(errCount), 32'd3);
    applyStimulus(1'b1, 32'h0000_0040, 4'h3, 32'h5555_AAAA);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, boundary[i], 4'hF, 32'h0);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: addr = 32'($urandom_range(0, 32'h0FFF));
        1: addr = 32'h1000 + 32'($urandom_range(0, 32'h0FFF));
        2: addr = 32'h2000 + 32'($urandom_range(0, 32'hDFFF));
        default: addr = $urandom | 32'h0001_0000;
      endcase
      applyStimulus(1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom);
    end

    $display("[TB] error counter saturation");
    while (modelErrCount < 255) applyStimulus(1'b0, 32'h0000_3000, 4'hF, 32'h0);
    checkOutput("errCountFull", 32'(errCount), 32'd255);
    applyStimulus(1'b1, 32'h0000_4000, 4'hF, 32'h1);
    checkOutput("errCountSaturated", 32'(errCount), 32'd255);

    $display("[TB] reset during a RAM read");
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0001_0020;
    bus.cpu_sel = 4'hF; bus.cpu_wdata = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("midReadRamCe", 32'(ramCe), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abortRamCe", 32'(ramCe), 32'd0);
    checkOutput("abortDevAddr", devAddr, 32'd0);
    checkOutput("abortErrCount", 32'(errCount), 32'd0);
    bus.cpu_req = 1'b0;
    modelErrCount = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("abortNoAck", 32'(bus.cpu_ack), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0001_0020, 4'hF, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
